// File: rtl/sc_reggeneral_arbiter_if.sv
// Bus bundle between requesters and the shared-register arbiter.
// The lock vector exists only when SC_REGARBITER_LOCK_EN is defined.
interface sc_reggeneral_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int RegARBITER_DATAWIDTH = 8,
   parameter int ID_W = 2
);
   logic [NUM_REQ-1:0] SC_RegARBITER_req_InBUS;
   logic [NUM_REQ-1:0] SC_RegARBITER_op_InBUS;
   logic [NUM_REQ*RegARBITER_DATAWIDTH-1:0] SC_RegARBITER_data_InBUS;
`ifdef SC_REGARBITER_LOCK_EN
   logic [NUM_REQ-1:0] SC_RegARBITER_lock_InBUS;
`endif
   logic [NUM_REQ-1:0] SC_RegARBITER_ack_OutBUS;
   logic [ID_W-1:0] SC_RegARBITER_grantID_OutBUS;
   logic SC_RegARBITER_busy_Out;
   logic SC_RegARBITER_load_OutLow;
   logic SC_RegARBITER_clear_OutLow;
   logic [RegARBITER_DATAWIDTH-1:0] SC_RegARBITER_data_OutBUS;

   modport master (
      output SC_RegARBITER_req_InBUS,
      output SC_RegARBITER_op_InBUS,
      output SC_RegARBITER_data_InBUS,
`ifdef SC_REGARBITER_LOCK_EN
      output SC_RegARBITER_lock_InBUS,
`endif
      input  SC_RegARBITER_ack_OutBUS,
      input  SC_RegARBITER_grantID_OutBUS,
      input  SC_RegARBITER_busy_Out,
      input  SC_RegARBITER_load_OutLow,
      input  SC_RegARBITER_clear_OutLow,
      input  SC_RegARBITER_data_OutBUS
   );

   modport slave (
      input  SC_RegARBITER_req_InBUS,
      input  SC_RegARBITER_op_InBUS,
      input  SC_RegARBITER_data_InBUS,
`ifdef SC_REGARBITER_LOCK_EN
      input  SC_RegARBITER_lock_InBUS,
`endif
      output SC_RegARBITER_ack_OutBUS,
      output SC_RegARBITER_grantID_OutBUS,
      output SC_RegARBITER_busy_Out,
      output SC_RegARBITER_load_OutLow,
      output SC_RegARBITER_clear_OutLow,
      output SC_RegARBITER_data_OutBUS
   );
endinterface

// File: rtl/sc_reggeneral_arbiter.sv
// Round-robin sequencer sharing one register among NUM_REQ requesters.
// Define SC_REGARBITER_LOCK_EN to let a winner hold the round-robin pointer.
module sc_reggeneral_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int RegARBITER_DATAWIDTH = 8,
   parameter int ID_W = 2
) (
   input  logic SC_RegARBITER_CLOCK_50,
   input  logic SC_RegARBITER_RESET_InLow,
   sc_reggeneral_arbiter_if.slave bus
);
   localparam int W = RegARBITER_DATAWIDTH;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t stateQ, stateD;
   logic [ID_W-1:0] ptrQ, ptrD;
   logic [ID_W-1:0] gidQ, gidD;
   logic [NUM_REQ-1:0] ackQ, ackD;
   logic busyQ, busyD;
   logic loadQ, loadD;
   logic clearQ, clearD;
   logic [W-1:0] dataQ, dataD;

   logic [2*NUM_REQ-1:0] reqDbl;
   logic [NUM_REQ-1:0] reqRot;
   logic found;
   logic [ID_W-1:0] pick;
   logic lockHit;
   int sum;

   // Rotate so bit 0 is the pointer position; lowest set bit wins.
   always_comb begin
      reqDbl = {bus.SC_RegARBITER_req_InBUS,
                bus.SC_RegARBITER_req_InBUS} >> ptrQ;
      reqRot = reqDbl[NUM_REQ-1:0];
      found = 1'b0;
      pick = '0;
      sum = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (reqRot[k]) begin
            sum = int'(ptrQ) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            found = 1'b1;
            pick = ID_W'(sum);
         end
      end
   end

`ifdef SC_REGARBITER_LOCK_EN
   assign lockHit = bus.SC_RegARBITER_lock_InBUS[gidQ];
`else
   assign lockHit = 1'b0;
`endif

   always_comb begin
      stateD = stateQ;
      ptrD = ptrQ;
      gidD = gidQ;
      ackD = '0;
      loadD = 1'b1;
      clearD = 1'b1;
      dataD = dataQ;
      unique case (stateQ)
         IDLE: begin
            if (found) begin
               stateD = EXEC;
               gidD = pick;
               dataD = bus.SC_RegARBITER_data_InBUS[pick*W +: W];
               if (bus.SC_RegARBITER_op_InBUS[pick]) clearD = 1'b0;
               else loadD = 1'b0;
            end
         end
         EXEC: begin
            stateD = DONE;
            ackD = NUM_REQ'(1) << gidQ;
         end
         DONE: begin
            stateD = IDLE;
            if (lockHit) ptrD = gidQ;
            else if (gidQ == ID_W'(NUM_REQ - 1)) ptrD = '0;
            else ptrD = gidQ + 1'b1;
         end
         default: stateD = IDLE;
      endcase
      busyD = (stateD != IDLE);
   end

   always_ff @(posedge SC_RegARBITER_CLOCK_50
               or negedge SC_RegARBITER_RESET_InLow) begin
      if (!SC_RegARBITER_RESET_InLow) begin
         stateQ <= IDLE;
         ptrQ <= '0;
         gidQ <= '0;
         ackQ <= '0;
         busyQ <= 1'b0;
         loadQ <= 1'b1;
         clearQ <= 1'b1;
         dataQ <= '0;
      end else begin
         stateQ <= stateD;
         ptrQ <= ptrD;
         gidQ <= gidD;
         ackQ <= ackD;
         busyQ <= busyD;
         loadQ <= loadD;
         clearQ <= clearD;
         dataQ <= dataD;
      end
   end

   assign bus.SC_RegARBITER_ack_OutBUS = ackQ;
   assign bus.SC_RegARBITER_grantID_OutBUS = gidQ;
   assign bus.SC_RegARBITER_busy_Out = busyQ;
   assign bus.SC_RegARBITER_load_OutLow = loadQ;
   assign bus.SC_RegARBITER_clear_OutLow = clearQ;
   assign bus.SC_RegARBITER_data_OutBUS = dataQ;
endmodule

// File: doc/sc_reggeneral_arbiter.md
Name: sc_reggeneral_arbiter

Overview:
Round-robin arbiter and sequencer that shares one general-purpose register (8-bit default, active-low load/clear strobes) among NUM_REQ requesters.
- Each requester asks for a LOAD or a CLEAR operation.
- The block picks one winner, drives the register's data bus and strobe for exactly one cycle, then returns a one-cycle ack to that requester.
- It sits between the control units and the shared register instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
RegARBITER_DATAWIDTH, 8, data width; must match the shared register
ID_W, 2, width of grant index; must equal ceil(log2(NUM_REQ))

Ports:
SC_RegARBITER_CLOCK_50  in  1  system clock, rising edge
SC_RegARBITER_RESET_InLow  in  1  asynchronous active-low reset
SC_RegARBITER_req_InBUS  in  NUM_REQ  level request, one bit per requester
SC_RegARBITER_op_InBUS  in  NUM_REQ  per-requester op: 1=CLEAR, 0=LOAD
SC_RegARBITER_data_InBUS  in  NUM_REQ*DATAWIDTH  flattened load data; requester i at bits [i*W +: W]
SC_RegARBITER_ack_OutBUS  out  NUM_REQ  one-cycle completion pulse to the winner
SC_RegARBITER_grantID_OutBUS  out  ID_W  index of the current or last winner
SC_RegARBITER_busy_Out  out  1  high while the state is not IDLE
SC_RegARBITER_load_OutLow  out  1  register load strobe, active low
SC_RegARBITER_clear_OutLow  out  1  register clear strobe, active low
SC_RegARBITER_data_OutBUS  out  DATAWIDTH  data to the register's data input

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low (SC_RegARBITER_RESET_InLow); all state is reset asynchronously.
- Reset values:
  - state=IDLE, pointer=0
  - ack=0, grantID=0, busy=0
  - load_OutLow=1, clear_OutLow=1, data_OutBUS=0
- All outputs are registered.
- FSM: IDLE -> EXEC -> DONE -> IDLE.
- IDLE:
  - If req is non-zero, select the first set bit searching upward from pointer, wrapping NUM_REQ-1 -> 0.
  - Latch winner ID, op[winner] and data[winner]; go to EXEC.
  - If req is all zero, stay in IDLE.
- EXEC (exactly one cycle):
  - data_OutBUS = latched data.
  - If op=CLEAR: clear_OutLow=0, load_OutLow=1.
  - If op=LOAD: load_OutLow=0, clear_OutLow=1.
  - Never both low. Go to DONE.
- DONE (one cycle):
  - Strobes return to 1.
  - ack[winner]=1, all other ack bits 0.
  - pointer = (winner+1) mod NUM_REQ.
  - Go to IDLE.
- data_OutBUS holds its last value outside EXEC.
- Latency: req sampled at edge N (IDLE) -> strobe low in cycle N+1 -> ack high in cycle N+2. Back-to-back service every 3 cycles.
- Handshake:
  - req is level; op and data are sampled only at the grant edge, so later changes are ignored.
  - The requester must drop req in the cycle after ack. A req still high on the return to IDLE is a new request.
  - A request withdrawn before grant is simply not served; no error.
- Simultaneous requests: exactly one grant per arbitration. Under continuous all-high requests, service order is strictly round-robin starting at pointer.
- Wrap-around: with winner = NUM_REQ-1, pointer wraps to 0.
- Reset mid-operation: immediate return to reset values. No strobe and no ack is produced for the interrupted operation.
- busy = 1 in EXEC and DONE, 0 in IDLE.

Optional Feature:
Macro SC_REGARBITER_LOCK_EN.
- Defined:
  - Adds input SC_RegARBITER_lock_InBUS [NUM_REQ].
  - In DONE, if lock[winner]=1, pointer is set to winner, not winner+1. The same requester therefore wins the next arbitration if it is still requesting.
  - The lock bit is sampled at the DONE edge.
- Undefined: the port is absent and arbitration is pure round-robin.

Test Plan:
1. Reset low mid-run, then release with req=0 -> outputs at reset values, busy=0, strobes=1, ack=0 for 5 cycles.
2. Single LOAD: req=4'b0010, op=0, data[1]=8'hA5 -> cycle+1: load_OutLow=0, data_OutBUS=8'hA5, clear_OutLow=1; cycle+2: ack=4'b0010, grantID=1.
3. CLEAR: req=4'b1000, op[3]=1 -> one cycle clear_OutLow=0, load_OutLow=1; then ack=4'b1000; pointer wraps to 0.
4. All four requesting, each dropping req after its ack, pointer=0 -> grants in order 0,1,2,3, one every 3 cycles; data_OutBUS shows each requester's word in its EXEC cycle.
5. Reset asserted in EXEC during a LOAD by requester 2 -> strobes go to 1 immediately; no ack for requester 2; first grant after release goes to requester 0.
6. (LOCK_EN) Requesters 1 and 2 both requesting, lock[1]=1 -> requester 1 granted twice in a row; after lock[1]=0, requester 2 is granted next.
